// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and helpers for the memory-stage load/store sequencer.
package mem_access_ctrl_pkg;

  typedef logic [2:0] msize_t;

  localparam msize_t MSIZE1 = 3'd0;
  localparam msize_t MSIZE2 = 3'd1;
  localparam msize_t MSIZE4 = 3'd2;
  localparam msize_t MSIZE8 = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } state_e;

  // Extend already-shifted load data according to the load flavour in funct3.
  function automatic logic [63:0] load_extend(input logic [2:0] funct3,
                                              input logic [63:0] data);
    logic [63:0] res;
    case (funct3)
      3'd0:    res = {{56{data[7]}}, data[7:0]};
      3'd1:    res = {{48{data[15]}}, data[15:0]};
      3'd2:    res = {{32{data[31]}}, data[31:0]};
      3'd4:    res = {56'd0, data[7:0]};
      3'd5:    res = {48'd0, data[15:0]};
      3'd6:    res = {32'd0, data[31:0]};
      default: res = data;
    endcase
    return res;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size_code,
                                         input logic [2:0] offset);
    logic bad;
    case (msize_t'({1'b0, size_code}))
      MSIZE1:  bad = 1'b0;
      MSIZE2:  bad = offset[0];
      MSIZE4:  bad = |offset[1:0];
      default: bad = |offset;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment: store strobes/data placement and load shift/extension.
module mem_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [2:0]  offset,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata_raw,
  output logic [7:0]  strobe,
  output logic [63:0] store_data,
  output logic [63:0] load_data
);

  logic [7:0] base_mask;
  logic [5:0] bit_shift;

  always_comb begin
    base_mask = 8'hFF;
    case (funct3[1:0])
      2'd0:    base_mask = 8'h01;
      2'd1:    base_mask = 8'h03;
      2'd2:    base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
  end

  assign bit_shift  = {offset, 3'b000};
  assign strobe     = base_mask << offset;
  assign store_data = wdata << bit_shift;
  assign load_data  = load_extend(funct3, rdata_raw >> bit_shift);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store sequencer: runs one bus transaction per memory
// instruction and stalls the pipeline front until it completes.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        is_mem_read,
  input  logic        is_mem_write,
  input  logic [3:0]  mem_mode,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [63:0] rdata,
  output logic        misalign,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data
);

  state_e      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        write_q, write_d;
  logic [63:0] rdata_q, rdata_d;
  logic        misalign_q, misalign_d;

  logic        access;
  logic        is_write;
  logic        bad_funct3;
  logic        misaligned;
  logic [7:0]  strobe;
  logic [63:0] store_data;
  logic [63:0] load_data;

  assign access     = is_mem_read | is_mem_write;
  assign is_write   = mem_mode[3];
  assign bad_funct3 = is_write ? mem_mode[2] : (mem_mode[2:0] == 3'd7);
  assign misaligned = is_misaligned(mem_mode[1:0], addr[2:0]);

  mem_align u_align (
    .funct3     (funct3_q),
    .offset     (addr_q[2:0]),
    .wdata      (wdata_q),
    .rdata_raw  (dresp_data),
    .strobe     (strobe),
    .store_data (store_data),
    .load_data  (load_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      funct3_q   <= '0;
      write_q    <= 1'b0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      funct3_q   <= funct3_d;
      write_q    <= write_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
  end

  // DONE always returns to IDLE so the instruction still held on mem_valid
  // during its completion cycle cannot launch a second time.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    funct3_d   = funct3_q;
    write_d    = write_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_valid && access) begin
          rdata_d = '0;
          if (misaligned || bad_funct3) begin
            misalign_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            misalign_d = 1'b0;
            addr_d     = addr;
            wdata_d    = wdata;
            funct3_d   = mem_mode[2:0];
            write_d    = is_write;
            state_d    = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (dresp_addr_ok) begin
          if (dresp_data_ok) begin
            rdata_d = write_q ? '0 : load_data;
            state_d = ST_DONE;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (dresp_data_ok) begin
          rdata_d = write_q ? '0 : load_data;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset gates stall so every output reads 0 while reset is held.
  assign stall       = reset & mem_valid & access & (state_q != ST_DONE);
  assign resp_valid  = (state_q == ST_DONE);
  assign misalign    = resp_valid & misalign_q;
  assign rdata       = rdata_q;
  assign dreq_valid  = (state_q == ST_ADDR);
  assign dreq_addr   = addr_q;
  assign dreq_size   = msize_t'({1'b0, funct3_q[1:0]});
  assign dreq_strobe = write_q ? strobe : 8'h00;
  assign dreq_data   = write_q ? store_data : 64'd0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl.
module tb_mem_access_ctrl;

  logic        clk;
  logic        reset;
  logic        mem_valid;
  logic        is_mem_read;
  logic        is_mem_write;
  logic [3:0]  mem_mode;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        stall;
  logic        resp_valid;
  logic [63:0] rdata;
  logic        misalign;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;

  int checkCount = 0;
  int errCount   = 0;

  localparam logic [63:0] GARBAGE = 64'hA5A5_A5A5_A5A5_A5A5;

  mem_access_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .mem_valid     (mem_valid),
    .is_mem_read   (is_mem_read),
    .is_mem_write  (is_mem_write),
    .mem_mode      (mem_mode),
    .addr          (addr),
    .wdata         (wdata),
    .stall         (stall),
    .resp_valid    (resp_valid),
    .rdata         (rdata),
    .misalign      (misalign),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_addr_ok (dresp_addr_ok),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic rd, input logic wr,
                               input logic [3:0] mode, input logic [63:0] a,
                               input logic [63:0] wd);
    mem_valid    = v;
    is_mem_read  = rd;
    is_mem_write = wr;
    mem_mode     = mode;
    addr         = a;
    wdata        = wd;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".stall"},       64'(stall),       64'd0);
    checkOutput({tag, ".resp_valid"},  64'(resp_valid),  64'd0);
    checkOutput({tag, ".misalign"},    64'(misalign),    64'd0);
    checkOutput({tag, ".rdata"},       rdata,            64'd0);
    checkOutput({tag, ".dreq_valid"},  64'(dreq_valid),  64'd0);
    checkOutput({tag, ".dreq_addr"},   dreq_addr,        64'd0);
    checkOutput({tag, ".dreq_size"},   64'(dreq_size),   64'd0);
    checkOutput({tag, ".dreq_strobe"}, 64'(dreq_strobe), 64'd0);
    checkOutput({tag, ".dreq_data"},   dreq_data,        64'd0);
  endtask

  task automatic idleCycles(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 64'd0, 64'd0);
      dresp_addr_ok = 1'b0;
      dresp_data_ok = 1'b0;
      @(negedge clk);
      checkOutput({tag, ".idle_resp"},  64'(resp_valid), 64'd0);
      checkOutput({tag, ".idle_dreq"},  64'(dreq_valid), 64'd0);
      checkOutput({tag, ".idle_stall"}, 64'(stall),      64'd0);
    end
  endtask

  // Launches one access in the next cycle; addrDelay extra ADDR cycles before
  // addr_ok (with a stray data_ok in the first one), then dataDelay DATA cycles.
  task automatic runAccess(input string tag, input logic wr, input logic [2:0] f3,
                           input logic [63:0] a, input logic [63:0] wd,
                           input logic [63:0] bus, input int addrDelay,
                           input int dataDelay, input logic [7:0] expStrobe,
                           input logic [2:0] expSize, input logic [63:0] expData,
                           input logic [63:0] expRdata);
    int validCycles = 0;
    logic fin;
    @(posedge clk); #1;
    applyStimulus(1'b1, ~wr, wr, {wr, f3}, a, wd);
    @(negedge clk);
    checkOutput({tag, ".c0_stall"}, 64'(stall),      64'd1);
    checkOutput({tag, ".c0_dreq"},  64'(dreq_valid), 64'd0);
    checkOutput({tag, ".c0_resp"},  64'(resp_valid), 64'd0);
    for (int i = 0; i <= addrDelay; i++) begin
      @(posedge clk); #1;
      fin           = (i == addrDelay);
      dresp_addr_ok = fin;
      dresp_data_ok = (fin && dataDelay == 0) || (i == 0 && addrDelay > 0);
      dresp_data    = (fin && dataDelay == 0) ? bus : GARBAGE;
      @(negedge clk);
      if (dreq_valid) validCycles++;
      checkOutput({tag, ".addr"},   dreq_addr,        a);
      checkOutput({tag, ".size"},   64'(dreq_size),   64'(expSize));
      checkOutput({tag, ".strobe"}, 64'(dreq_strobe), 64'(expStrobe));
      if (wr) checkOutput({tag, ".wdata"}, dreq_data, expData);
      checkOutput({tag, ".a_stall"}, 64'(stall), 64'd1);
    end
    for (int j = 1; j <= dataDelay; j++) begin
      @(posedge clk); #1;
      dresp_addr_ok = 1'b0;
      dresp_data_ok = (j == dataDelay);
      dresp_data    = (j == dataDelay) ? bus : GARBAGE;
      @(negedge clk);
      checkOutput({tag, ".d_dreq"},  64'(dreq_valid), 64'd0);
      checkOutput({tag, ".d_stall"}, 64'(stall),      64'd1);
    end
    @(posedge clk); #1;
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data    = GARBAGE;
    @(negedge clk);
    checkOutput({tag, ".resp"},     64'(resp_valid), 64'd1);
    checkOutput({tag, ".done_stall"}, 64'(stall),    64'd0);
    checkOutput({tag, ".misalign"}, 64'(misalign),   64'd0);
    checkOutput({tag, ".rdata"},    rdata,           expRdata);
    checkOutput({tag, ".dreq_cycles"}, 64'(validCycles), 64'(addrDelay + 1));
  endtask

  task automatic runFault(input string tag, input logic wr, input logic [2:0] f3,
                          input logic [63:0] a);
    @(posedge clk); #1;
    applyStimulus(1'b1, ~wr, wr, {wr, f3}, a, 64'h1234);
    @(negedge clk);
    checkOutput({tag, ".c0_stall"}, 64'(stall),      64'd1);
    checkOutput({tag, ".c0_dreq"},  64'(dreq_valid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput({tag, ".resp"},     64'(resp_valid), 64'd1);
    checkOutput({tag, ".misalign"}, 64'(misalign),   64'd1);
    checkOutput({tag, ".dreq"},     64'(dreq_valid), 64'd0);
    checkOutput({tag, ".stall"},    64'(stall),      64'd0);
  endtask

  initial begin
    reset         = 1'b0;
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data    = 64'd0;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 64'd0, 64'd0);
    #2;
    checkAllZero("reset");
    #20 reset = 1'b1;

    runAccess("sd", 1'b1, 3'd3, 64'h8000_0008, 64'h1122_3344_5566_7788, 64'd0,
              0, 0, 8'hFF, 3'd3, 64'h1122_3344_5566_7788, 64'd0);
    idleCycles("sd", 1);
    runAccess("sb", 1'b1, 3'd0, 64'h8000_0003, 64'h0000_0000_0000_00AB, 64'd0,
              0, 0, 8'h08, 3'd0, 64'h0000_0000_AB00_0000, 64'd0);
    runAccess("sh", 1'b1, 3'd1, 64'h8000_0006, 64'h0000_0000_0000_1234, 64'd0,
              0, 0, 8'hC0, 3'd1, 64'h1234_0000_0000_0000, 64'd0);
    runAccess("lb", 1'b0, 3'd0, 64'h8000_0005, 64'd0, 64'h0000_8000_0000_0000,
              0, 0, 8'h00, 3'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FF80);
    runAccess("lbu", 1'b0, 3'd4, 64'h8000_0005, 64'd0, 64'h0000_8000_0000_0000,
              0, 0, 8'h00, 3'd0, 64'd0, 64'h0000_0000_0000_0080);
    runAccess("lw", 1'b0, 3'd2, 64'h8000_0004, 64'd0, 64'h8000_0000_0000_0000,
              0, 0, 8'h00, 3'd2, 64'd0, 64'hFFFF_FFFF_8000_0000);
    runAccess("lwu", 1'b0, 3'd6, 64'h8000_0004, 64'd0, 64'h8000_0000_1234_5678,
              0, 0, 8'h00, 3'd2, 64'd0, 64'h0000_0000_8000_0000);
    runAccess("ld_slow", 1'b0, 3'd3, 64'h8000_0010, 64'd0, 64'h0123_4567_89AB_CDEF,
              3, 2, 8'h00, 3'd3, 64'd0, 64'h0123_4567_89AB_CDEF);
    idleCycles("ld_slow", 1);

    runFault("lw_mis", 1'b0, 3'd2, 64'h8000_0002);
    idleCycles("lw_mis", 1);
    runFault("ld_f7", 1'b0, 3'd7, 64'h8000_0008);
    idleCycles("ld_f7", 1);
    runFault("st_f4", 1'b1, 3'd4, 64'h8000_0008);
    idleCycles("st_f4", 1);

    // Reset in the middle of a load's DATA phase.
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd3, 64'h8000_0020, 64'd0);
    @(posedge clk); #1;
    dresp_addr_ok = 1'b1;
    dresp_data_ok = 1'b0;
    @(posedge clk); #1;
    dresp_addr_ok = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid.data_dreq",  64'(dreq_valid), 64'd0);
    checkOutput("rst_mid.data_stall", 64'(stall),      64'd1);
    #2 reset = 1'b0;
    #1;
    checkAllZero("rst_mid");
    @(posedge clk); #1;
    dresp_data_ok = 1'b1;
    dresp_data    = GARBAGE;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 64'd0, 64'd0);
    @(posedge clk); #1;
    dresp_data_ok = 1'b0;
    #2 reset = 1'b1;
    idleCycles("rst_after", 3);
    runAccess("lh_post", 1'b0, 3'd1, 64'h8000_0002, 64'd0, 64'h0000_0000_FFFE_0000,
              0, 0, 8'h00, 3'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE);
    idleCycles("lh_post", 2);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
